// File: rtl/cdf_generator.sv
// -----------------------------------------------------------------------------
// cdf_generator
//   Producer side of the histogram-equalisation divider interface. A frame of
//   NUM_PIXELS pixels is first binned into a 2^PIX_W-entry histogram. The bins
//   are then walked in order, and each bin's running cumulative count is
//   presented on cdf_out. A one-cycle div_en pulse starts the divider, and the
//   block waits for ready_g_out before it moves on to the next bin.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   pix_valid    in   1      pix_in valid this cycle
//   pix_in       in   PIX_W  pixel gray level
//   pix_ready    out  1      pixel accepted when pix_valid & pix_ready
//   cdf_out      out  CNT_W  cumulative count for bin bin_idx (divider cdf_in)
//   div_en       out  1      one-cycle divider start pulse
//   ready_g_out  in   1      divider finished the current bin
//   bin_idx      out  PIX_W  bin currently presented on cdf_out
//   frame_done   out  1      one-cycle pulse after the last bin completes
// -----------------------------------------------------------------------------
module cdf_generator #(
  parameter int NUM_PIXELS = 64,
  parameter int PIX_W      = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_ready,
  output logic [CNT_W-1:0] cdf_out,
  output logic             div_en,
  input  logic             ready_g_out,
  output logic [PIX_W-1:0] bin_idx,
  output logic             frame_done
);

  localparam int NBINS = 2 ** PIX_W;
  localparam int PC_W  = $clog2(NUM_PIXELS + 1);

  localparam logic [PC_W-1:0]  LAST_PIX = PC_W'(NUM_PIXELS - 1);
  localparam logic [PC_W-1:0]  PIX_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  PIX_ZERO = {PC_W{1'b0}};
  localparam logic [PIX_W-1:0] BIN_ONE  = {{(PIX_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] BIN_ZERO = {PIX_W{1'b0}};
  localparam logic [PIX_W-1:0] BIN_LAST = {PIX_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_ACCUM  = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] hist_r [NBINS];
  logic [PC_W-1:0]  pix_cnt_r;
  logic [CNT_W-1:0] sum_r;
  logic [CNT_W-1:0] sum_next_s;
  logic             xfer_s;
  logic             last_pix_s;
  logic             last_bin_s;

  // Unsigned add that clamps at the counter maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W]) begin
      sat_add = CNT_MAX;
    end else begin
      sat_add = s[CNT_W-1:0];
    end
  endfunction

  // Decode accepted pixels, frame/bin boundaries and the next cumulative sum.
  always_comb begin
    xfer_s     = (state_r == ST_ACCUM) && pix_valid;
    last_pix_s = (pix_cnt_r == LAST_PIX);
    last_bin_s = (bin_idx == BIN_LAST);
    sum_next_s = sat_add(sum_r, hist_r[bin_idx]);
  end

  // Next-state logic. ready_g_out is only looked at in ST_WAIT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (xfer_s && last_pix_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_LOAD:   state_s = ST_SETTLE;
      ST_SETTLE: state_s = ST_START;
      ST_START:  state_s = ST_WAIT;
      ST_WAIT: begin
        if (ready_g_out) begin
          if (last_bin_s) begin
            state_s = ST_ACCUM;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_s;
    end
  end

  // Histogram, running sum, pixel count and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBINS; i++) begin
        hist_r[i] <= CNT_ZERO;
      end
      pix_cnt_r  <= PIX_ZERO;
      sum_r      <= CNT_ZERO;
      cdf_out    <= CNT_ZERO;
      bin_idx    <= BIN_ZERO;
      pix_ready  <= 1'b1;
      div_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Output flags are derived from the next state so that they line up
      // with the state they belong to.
      pix_ready  <= (state_s == ST_ACCUM);
      div_en     <= (state_s == ST_START);
      frame_done <= (state_r == ST_WAIT) && ready_g_out && last_bin_s;
      case (state_r)
        ST_ACCUM: begin
          if (xfer_s) begin
            hist_r[pix_in] <= sat_add(hist_r[pix_in], CNT_ONE);
            pix_cnt_r      <= pix_cnt_r + PIX_ONE;
          end
        end
        ST_LOAD: begin
          // Emptying the bin here leaves the histogram clean for the next frame.
          cdf_out         <= sum_next_s;
          sum_r           <= sum_next_s;
          hist_r[bin_idx] <= CNT_ZERO;
        end
        ST_WAIT: begin
          if (ready_g_out) begin
            if (last_bin_s) begin
              pix_cnt_r <= PIX_ZERO;
              sum_r     <= CNT_ZERO;
              bin_idx   <= BIN_ZERO;
            end else begin
              bin_idx <= bin_idx + BIN_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdf_generator.sv
// -----------------------------------------------------------------------------
// tb_cdf_generator
//   Self-checking bench for cdf_generator. Two instances are used: one with
//   the default 64-pixel frame and one with a 300-pixel frame, which exercises
//   bin saturation. A select line routes the shared stimulus to one of them.
//   The expected CDF comes from a plain integer histogram of the pixels sent.
// -----------------------------------------------------------------------------
module tb_cdf_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_in = 8'd0;
  logic       ready_g_out = 1'b0;
  logic       sel = 1'b0;

  logic       a_pix_ready, a_div_en, a_frame_done;
  logic [7:0] a_cdf_out, a_bin_idx;
  logic       b_pix_ready, b_div_en, b_frame_done;
  logic [7:0] b_cdf_out, b_bin_idx;

  logic       m_pix_ready, m_div_en, m_frame_done;
  logic [7:0] m_cdf_out, m_bin_idx;

  int total = 0;
  int bad = 0;
  int den_cnt = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  cdf_generator #(.NUM_PIXELS(64), .PIX_W(8), .CNT_W(8)) dut64 (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid & ~sel), .pix_in(pix_in), .pix_ready(a_pix_ready),
    .cdf_out(a_cdf_out), .div_en(a_div_en), .ready_g_out(ready_g_out & ~sel),
    .bin_idx(a_bin_idx), .frame_done(a_frame_done)
  );

  cdf_generator #(.NUM_PIXELS(300), .PIX_W(8), .CNT_W(8)) dut300 (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid & sel), .pix_in(pix_in), .pix_ready(b_pix_ready),
    .cdf_out(b_cdf_out), .div_en(b_div_en), .ready_g_out(ready_g_out & sel),
    .bin_idx(b_bin_idx), .frame_done(b_frame_done)
  );

  assign m_pix_ready  = sel ? b_pix_ready  : a_pix_ready;
  assign m_div_en     = sel ? b_div_en     : a_div_en;
  assign m_frame_done = sel ? b_frame_done : a_frame_done;
  assign m_cdf_out    = sel ? b_cdf_out    : a_cdf_out;
  assign m_bin_idx    = sel ? b_bin_idx    : a_bin_idx;

  // Count start pulses and frame completions of the selected instance.
  always @(negedge clk) begin
    if (m_div_en) den_cnt <= den_cnt + 1;
    if (m_frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 random, 1 all zero, 2 ramp, 3 all 200, 4 all 5, 5 random 0..3
  // lat_fix < 0 picks a random divider latency per bin.
  // abort_bin >= 0 applies reset while waiting on that bin.
  task automatic run_frame(input int npix, input int mode, input int lat_fix,
                           input bit stray, input bit hold_valid,
                           input int abort_bin);
    int pq[$];
    int h[256];
    int ex[256];
    int s, p, lat, den0, fd0, wc;
    sel = (npix > 64);
    for (int i = 0; i < npix; i++) begin
      case (mode)
        0: p = $urandom_range(0, 255);
        1: p = 0;
        2: p = i;
        3: p = 200;
        4: p = 5;
        5: p = $urandom_range(0, 3);
        default: p = 0;
      endcase
      pq.push_back(p);
    end
    for (int b = 0; b < 256; b++) h[b] = 0;
    foreach (pq[i]) h[pq[i]]++;
    s = 0;
    for (int b = 0; b < 256; b++) begin
      s += (h[b] > 255) ? 255 : h[b];
      if (s > 255) s = 255;
      ex[b] = s;
    end
    @(negedge clk);
    den0 = den_cnt;
    fd0 = fd_cnt;
    foreach (pq[i]) begin
      if ((mode == 0 || mode == 5) && $urandom_range(0, 3) == 0) begin
        pix_valid = 1'b0;
        @(negedge clk);
      end
      check_val("pix_ready_accum", m_pix_ready, 1);
      pix_valid = 1'b1;
      pix_in = 8'(pq[i]);
      @(negedge clk);
    end
    if (hold_valid) pix_in = 8'($urandom_range(0, 255));
    else pix_valid = 1'b0;
    check_val("pix_ready_full", m_pix_ready, 0);
    for (int b = 0; b < 256; b++) begin
      wc = 0;
      while (!m_div_en && wc < 40) begin
        if (hold_valid) pix_in = 8'($urandom_range(0, 255));
        @(negedge clk);
        wc++;
      end
      if (!m_div_en) begin
        check_val("div_en_timeout", 0, 1);
        ready_g_out = 1'b0;
        pix_valid = 1'b0;
        return;
      end
      check_val("bin_idx", m_bin_idx, b);
      check_val("cdf_out", m_cdf_out, ex[b]);
      if (b == abort_bin) begin
        @(negedge clk);
        reset = 1'b1;
        pix_valid = 1'b0;
        @(negedge clk);
        check_val("rst_pix_ready", m_pix_ready, 1);
        check_val("rst_div_en", m_div_en, 0);
        check_val("rst_bin_idx", m_bin_idx, 0);
        check_val("rst_cdf_out", m_cdf_out, 0);
        reset = 1'b0;
        return;
      end
      lat = (lat_fix >= 0) ? lat_fix : $urandom_range(1, 5);
      repeat (lat) @(negedge clk);
      check_val("cdf_hold", m_cdf_out, ex[b]);
      check_val("bin_hold", m_bin_idx, b);
      ready_g_out = 1'b1;
      if (b == 255) pix_valid = 1'b0;
      @(negedge clk);
      check_val("frame_done", m_frame_done, (b == 255) ? 1 : 0);
      // Keep ready high through LOAD and SETTLE; it must be ignored there.
      if (stray) repeat (2) @(negedge clk);
      ready_g_out = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_val("div_en_count", den_cnt - den0, 256);
    check_val("frame_done_count", fd_cnt - fd0, 1);
    check_val("pix_ready_idle", m_pix_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_pix_ready", a_pix_ready, 1);
    check_val("reset_div_en", a_div_en, 0);
    check_val("reset_cdf_out", a_cdf_out, 0);
    check_val("reset_bin_idx", a_bin_idx, 0);
    check_val("reset_frame_done", a_frame_done, 0);
    check_val("reset_b_pix_ready", b_pix_ready, 1);
    reset = 1'b0;

    run_frame(64, 1, 5, 1'b0, 1'b0, -1);   // all zero, fixed latency 5
    run_frame(64, 2, -1, 1'b0, 1'b0, -1);  // ramp 0..63
    run_frame(64, 0, -1, 1'b0, 1'b0, -1);  // random frame ...
    run_frame(64, 3, -1, 1'b0, 1'b0, -1);  // ... followed by all 200
    run_frame(64, 0, -1, 1'b1, 1'b1, -1);  // held pix_valid, stray ready
    run_frame(64, 0, -1, 1'b0, 1'b0, 100); // reset in WAIT at bin 100
    run_frame(64, 0, -1, 1'b0, 1'b0, -1);  // fresh frame after reset
    run_frame(300, 4, -1, 1'b0, 1'b0, -1); // saturating single bin
    run_frame(300, 5, -1, 1'b1, 1'b0, -1); // saturating random
    run_frame(64, 5, -1, 1'b0, 1'b1, -1);  // random with collisions

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
